stoch_grad_engine: RTL and testbench

STOCH_GRAD_ENGINE -- requirements
Module: stoch_grad_engine

---
 rtl/stoch_grad_engine_if.sv | 27 ++
 rtl/stoch_grad_engine.sv | 152 +++++++++++++++
 tb/tb_stoch_grad_engine.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/stoch_grad_engine_if.sv
// Handshake bundle for stoch_grad_engine: flip-vector request side and masked-result side.
interface stoch_grad_engine_if #(
   parameter int W_SIZE = 3072
);
   localparam int KW = $clog2(W_SIZE + 1);

   logic              in_valid;
   logic              in_ready;
   logic [W_SIZE-1:0] flip_weight_in;
   logic [3:0]        neg_log_lr_in;
   logic              decay_en_in;
   logic              out_valid;
   logic              out_ready;
   logic [W_SIZE-1:0] flip_weight_out;
   logic [KW-1:0]     kept_count_out;
   logic [3:0]        lr_eff_out;

   modport master (
      output in_valid, flip_weight_in, neg_log_lr_in, decay_en_in, out_ready,
      input  in_ready, out_valid, flip_weight_out, kept_count_out, lr_eff_out
   );

   modport slave (
      input  in_valid, flip_weight_in, neg_log_lr_in, decay_en_in, out_ready,
      output in_ready, out_valid, flip_weight_out, kept_count_out, lr_eff_out
   );
endinterface

// File: rtl/stoch_grad_engine.sv
// Stochastic flip-mask engine: keeps each candidate flip with probability ~2^-n using an LFSR,
// one CHUNK per cycle, with an optional epoch-driven learning-rate decay.
module stoch_grad_engine #(
   parameter int W_SIZE       = 3072,
   parameter int CHUNK        = 256,
   parameter int RANDOM_SEED  = 1212,
   parameter int DECAY_EPOCHS = 16
) (
   input logic                 clk_in,
   input logic                 rst_in,
   stoch_grad_engine_if.slave  sgi
);
   localparam int NCHUNK = W_SIZE / CHUNK;
   localparam int KW     = $clog2(W_SIZE + 1);
   localparam int CW     = $clog2(CHUNK + 1);
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int EW     = $clog2(DECAY_EPOCHS + 1);
   localparam logic [31:0] SEED = (RANDOM_SEED == 0) ? 32'd1 : 32'(RANDOM_SEED);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [31:0]       lfsr_q, lfsr_d;
   logic [W_SIZE-1:0] din_q, din_d;
   logic [W_SIZE-1:0] dout_q, dout_d;
   logic [KW-1:0]     kept_q, kept_d;
   logic [3:0]        lr_q, lr_d;
   logic [IW-1:0]     chunk_q, chunk_d;
   logic [EW-1:0]     epoch_q, epoch_d;
   logic [3:0]        offs_q, offs_d;
   logic [CHUNK-1:0]  chunk_bits;
   logic              in_ready, out_valid;
   logic              last_chunk;

   // Bit i survives only if every selected LFSR tap for j < n is one; tap indices are elaboration constants.
   function automatic logic [CHUNK-1:0] mask_chunk(input logic [CHUNK-1:0] flips,
                                                   input logic [31:0] r, input logic [3:0] n);
      logic [CHUNK-1:0] m;
      int sel;
      m = flips;
      for (int i = 0; i < CHUNK; i++) begin
         for (int j = 0; j < 15; j++) begin
            sel = (51 * i * i + 19 * i * j) % 32;
            if (j < int'(n) && !r[sel[4:0]]) m[i] = 1'b0;
         end
      end
      return m;
   endfunction

   function automatic logic [CW-1:0] popcount(input logic [CHUNK-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < CHUNK; i++) c = c + CW'(v[i]);
      return c;
   endfunction

   function automatic logic [3:0] sat_lr(input logic [3:0] n, input logic [3:0] o);
      logic [4:0] s;
      s = {1'b0, n} + {1'b0, o};
      return (s > 5'd15) ? 4'd15 : s[3:0];
   endfunction

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state_q <= IDLE;
      else        state_q <= state_d;
   end

   assign last_chunk = (chunk_q == IW'(NCHUNK - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sgi.in_valid)  state_d = RUN;
         RUN:     if (last_chunk)    state_d = DONE;
         DONE:    if (sgi.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   always_comb begin
      din_d      = din_q;
      dout_d     = dout_q;
      kept_d     = kept_q;
      lr_d       = lr_q;
      chunk_d    = chunk_q;
      lfsr_d     = lfsr_q;
      epoch_d    = epoch_q;
      offs_d     = offs_q;
      chunk_bits = mask_chunk(din_q[chunk_q * CHUNK +: CHUNK], lfsr_q, lr_q);
      case (state_q)
         IDLE: if (sgi.in_valid) begin
            din_d   = sgi.flip_weight_in;
            dout_d  = '0;
            kept_d  = '0;
            chunk_d = '0;
            lr_d    = sat_lr(sgi.neg_log_lr_in, offs_q);
         end
         RUN: begin
            dout_d[chunk_q * CHUNK +: CHUNK] = chunk_bits;
            kept_d  = kept_q + KW'(popcount(chunk_bits));
            lfsr_d  = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
            chunk_d = last_chunk ? '0 : chunk_q + 1'b1;
         end
         default: ;
      endcase
      // Epochs count completed output handshakes; disabling decay forgets all accumulated offset.
      if (!sgi.decay_en_in) begin
         epoch_d = '0;
         offs_d  = '0;
      end else if (out_valid && sgi.out_ready) begin
         if (epoch_q == EW'(DECAY_EPOCHS - 1)) begin
            epoch_d = '0;
            if (offs_q != 4'd15) offs_d = offs_q + 4'd1;
         end else begin
            epoch_d = epoch_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         din_q   <= '0;
         dout_q  <= '0;
         kept_q  <= '0;
         lr_q    <= '0;
         chunk_q <= '0;
         lfsr_q  <= SEED;
         epoch_q <= '0;
         offs_q  <= '0;
      end else begin
         din_q   <= din_d;
         dout_q  <= dout_d;
         kept_q  <= kept_d;
         lr_q    <= lr_d;
         chunk_q <= chunk_d;
         lfsr_q  <= lfsr_d;
         epoch_q <= epoch_d;
         offs_q  <= offs_d;
      end
   end

   assign sgi.in_ready        = in_ready;
   assign sgi.out_valid       = out_valid;
   assign sgi.flip_weight_out = dout_q;
   assign sgi.kept_count_out  = kept_q;
   assign sgi.lr_eff_out      = lr_q;
endmodule

// File: tb/tb_stoch_grad_engine.sv
// Directed bench for stoch_grad_engine: latency, masking vs a bit-level model, backpressure,
// learning-rate decay and asynchronous reset abort.
module tb_stoch_grad_engine;
   localparam int W      = 3072;
   localparam int CHUNK  = 256;
   localparam int NCHUNK = W / CHUNK;
   localparam logic [31:0] SEED = 32'd1212;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [31:0] m_lfsr;
   logic [W-1:0] ones;
   logic [W-1:0] zeros;
   logic [W-1:0] pat;

   stoch_grad_engine_if #(.W_SIZE(W)) sgi ();

   stoch_grad_engine #(
      .W_SIZE(W), .CHUNK(CHUNK), .RANDOM_SEED(1212), .DECAY_EPOCHS(16)
   ) dut (
      .clk_in (clk),
      .rst_in (rst),
      .sgi    (sgi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      int k;
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         k = 0;
         for (int w = 0; w < W / 64; w++) begin
            if (got[w*64 +: 64] !== exp[w*64 +: 64]) begin
               k = w;
               break;
            end
         end
         $display("FAIL %s: got word%0d=%h required %h", tag, k, got[k*64 +: 64], exp[k*64 +: 64]);
      end
   endtask

   task automatic model_run(input logic [W-1:0] din, input int n,
                            output logic [W-1:0] dout, output int cnt);
      int   sel;
      logic keep;
      dout = '0;
      cnt  = 0;
      for (int c = 0; c < NCHUNK; c++) begin
         for (int i = 0; i < CHUNK; i++) begin
            keep = din[c*CHUNK + i];
            for (int j = 0; j < n; j++) begin
               sel = (51 * i * i + 19 * i * j) % 32;
               if (m_lfsr[sel[4:0]] == 1'b0) keep = 1'b0;
            end
            dout[c*CHUNK + i] = keep;
            if (keep) cnt++;
         end
         m_lfsr = {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0]};
      end
   endtask

   // Called on a negedge with the DUT idle; leaves on a negedge after the output handshake.
   task automatic run_vec(input string tag, input logic [W-1:0] din, input logic [3:0] n,
                          input int lr_exp);
      logic [W-1:0] exp_v;
      int exp_k;
      int lat;
      model_run(din, lr_exp, exp_v, exp_k);
      check_eq({tag, " in_ready"}, W'(sgi.in_ready), W'(1));
      sgi.flip_weight_in = din;
      sgi.neg_log_lr_in  = n;
      sgi.in_valid       = 1'b1;
      @(negedge clk);
      sgi.in_valid = 1'b0;
      lat = 0;
      while (!sgi.out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check_eq({tag, " latency"}, W'(lat), W'(NCHUNK));
      check_eq({tag, " flips"}, sgi.flip_weight_out, exp_v);
      check_eq({tag, " kept"}, W'(sgi.kept_count_out), W'(exp_k));
      check_eq({tag, " lr_eff"}, W'(sgi.lr_eff_out), W'(lr_exp));
      sgi.out_ready = 1'b1;
      @(negedge clk);
      sgi.out_ready = 1'b0;
   endtask

   initial begin
      logic [W-1:0] exp_v;
      int exp_k;
      int lat;
      ones  = '1;
      zeros = '0;
      sgi.in_valid       = 1'b0;
      sgi.flip_weight_in = '0;
      sgi.neg_log_lr_in  = 4'd0;
      sgi.decay_en_in    = 1'b0;
      sgi.out_ready      = 1'b0;
      rst = 1'b1;
      m_lfsr = SEED;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check_eq("rst in_ready", W'(sgi.in_ready), W'(1));
      check_eq("rst out_valid", W'(sgi.out_valid), W'(0));
      check_eq("rst flips", sgi.flip_weight_out, zeros);
      check_eq("rst kept", W'(sgi.kept_count_out), W'(0));
      check_eq("rst lr_eff", W'(sgi.lr_eff_out), W'(0));

      // n=0 passes everything: all ones, count 3072
      run_vec("n0 ones", ones, 4'd0, 0);
      check_eq("n0 kept const", W'(sgi.kept_count_out), W'(3072));

      run_vec("n8 first", ones, 4'd8, 8);
      pat = {W/4{4'b1010}};
      run_vec("n3 pattern", pat, 4'd3, 3);
      run_vec("n0 pattern", pat, 4'd0, 0);
      check_eq("n0 pattern flips const", sgi.flip_weight_out, pat);

      for (int v = 0; v < 64; v++) run_vec("n8 loop", ones, 4'd8, 8);

      run_vec("zeros n5", zeros, 4'd5, 5);
      check_eq("zeros flips const", sgi.flip_weight_out, zeros);
      check_eq("zeros kept const", W'(sgi.kept_count_out), W'(0));
      run_vec("after zeros n8", ones, 4'd8, 8);

      // Hold the result for 20 cycles while another vector is offered
      model_run(ones, 2, exp_v, exp_k);
      sgi.flip_weight_in = ones;
      sgi.neg_log_lr_in  = 4'd2;
      sgi.in_valid       = 1'b1;
      @(negedge clk);
      sgi.in_valid = 1'b0;
      lat = 0;
      while (!sgi.out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check_eq("bp latency", W'(lat), W'(NCHUNK));
      for (int k = 0; k < 20; k++) begin
         sgi.flip_weight_in = pat;
         sgi.neg_log_lr_in  = 4'd1;
         sgi.in_valid       = 1'b1;
         @(negedge clk);
         check_eq("bp out_valid", W'(sgi.out_valid), W'(1));
         check_eq("bp in_ready", W'(sgi.in_ready), W'(0));
         check_eq("bp flips", sgi.flip_weight_out, exp_v);
         check_eq("bp kept", W'(sgi.kept_count_out), W'(exp_k));
         check_eq("bp lr_eff", W'(sgi.lr_eff_out), W'(2));
      end
      sgi.in_valid  = 1'b0;
      sgi.out_ready = 1'b1;
      @(negedge clk);
      sgi.out_ready = 1'b0;
      run_vec("after bp", pat, 4'd1, 1);

      // Decay: base 14, offset reaches 1 after 16 handshakes, then saturated at 15
      sgi.decay_en_in = 1'b1;
      @(negedge clk);
      for (int v = 1; v <= 20; v++) run_vec("decay", ones, 4'd14, (v <= 16) ? 14 : 15);
      sgi.decay_en_in = 1'b0;
      @(negedge clk);
      run_vec("decay off", ones, 4'd14, 14);
      run_vec("decay off base3", ones, 4'd3, 3);

      // Asynchronous reset during chunk 5 aborts the vector
      sgi.flip_weight_in = ones;
      sgi.neg_log_lr_in  = 4'd8;
      sgi.in_valid       = 1'b1;
      @(negedge clk);
      sgi.in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check_eq("mid out_valid", W'(sgi.out_valid), W'(0));
      check_eq("mid in_ready", W'(sgi.in_ready), W'(0));
      #2 rst = 1'b1;
      #1;
      check_eq("arst out_valid", W'(sgi.out_valid), W'(0));
      check_eq("arst flips", sgi.flip_weight_out, zeros);
      check_eq("arst kept", W'(sgi.kept_count_out), W'(0));
      check_eq("arst lr_eff", W'(sgi.lr_eff_out), W'(0));
      @(negedge clk);
      rst = 1'b0;
      m_lfsr = SEED;
      @(negedge clk);
      check_eq("arst in_ready", W'(sgi.in_ready), W'(1));
      check_eq("arst out_valid idle", W'(sgi.out_valid), W'(0));
      run_vec("post-rst n0", ones, 4'd0, 0);
      run_vec("post-rst n8", ones, 4'd8, 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
